// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES decryption datapath.
// All GF multiplies are built from xtime chains.
package aes_dec_pkg;

    localparam int NUM_COLS = 4;

    typedef logic [0:127] state_t;
    typedef logic [0:31]  col_t;
    typedef logic [0:7]   byte_t;

    localparam byte_t RED_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Bit 0 is the MSB here, so a left shift drops b[0].
    function automatic byte_t xtime(input byte_t b);
        xtime = {b[1:7], 1'b0} ^ (b[0] ? RED_POLY : 8'h00);
    endfunction

    function automatic byte_t gmul_9(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul_9 = x8 ^ b;
    endfunction

    function automatic byte_t gmul_b(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul_b = x8 ^ x2 ^ b;
    endfunction

    function automatic byte_t gmul_d(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul_d = x8 ^ x4 ^ b;
    endfunction

    function automatic byte_t gmul_e(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul_e = x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on a single 32-bit column.
module inv_mix_column_word
    import aes_dec_pkg::*;
(
    input  col_t col_in,
    output col_t col_out
);

    localparam int ROWS = 4;

    byte_t a [ROWS];

    // Each output row is the circulant {E,B,D,9} rotated by the row index.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign a[gi] = col_in[8*gi +: 8];
        assign col_out[8*gi +: 8] = gmul_e(a[gi])
                                  ^ gmul_b(a[(gi + 1) % ROWS])
                                  ^ gmul_d(a[(gi + 2) % ROWS])
                                  ^ gmul_9(a[(gi + 3) % ROWS]);
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: one column per clock through a shared column datapath.
// Optional build macro IMC_BYPASS_EN adds a per-state bypass for the final round.
module inv_mix_columns_seq #(
    parameter int NUM_COLS = aes_dec_pkg::NUM_COLS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
`ifdef IMC_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out
);
    import aes_dec_pkg::*;

    localparam int CNT_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           work_q, work_d;
`ifdef IMC_BYPASS_EN
    logic             bypass_q, bypass_d;
`endif

    col_t   col_cur [NUM_COLS];
    col_t   mix_in, mix_out, col_res;
    state_t calc_word;

    assign mix_in = col_cur[cnt_q];

    inv_mix_column_word u_col (
        .col_in  (mix_in),
        .col_out (mix_out)
    );

`ifdef IMC_BYPASS_EN
    assign col_res = bypass_q ? mix_in : mix_out;
`else
    assign col_res = mix_out;
`endif

    // Only the column selected by the counter is rewritten; the rest pass through.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign col_cur[gi] = work_q[32*gi +: 32];
        assign calc_word[32*gi +: 32] = (cnt_q == CNT_W'(gi)) ? col_res : col_cur[gi];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        in_ready = 1'b0;
`ifdef IMC_BYPASS_EN
        bypass_d = bypass_q;
`endif
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            CALC: begin
                work_d = calc_word;
                if (cnt_q == LAST_COL) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new state may be taken from IDLE or on the same edge as the output handshake.
        if (in_valid && in_ready) begin
            work_d  = state_in;
            cnt_d   = '0;
            state_d = CALC;
`ifdef IMC_BYPASS_EN
            bypass_d = bypass;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
`ifdef IMC_BYPASS_EN
            bypass_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
`ifdef IMC_BYPASS_EN
            bypass_q <= bypass_d;
`endif
        end
    end

    assign out_valid = (state_q == DONE);
    assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: a matrix-level GF(2^8) model with a
// per-cycle scoreboard monitor, plus directed known-answer and handshake scenarios.
module tb_inv_mix_columns_seq;

    localparam logic [127:0] KAT1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KAT1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KAT2_IN  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
    localparam logic [127:0] KAT2_OUT = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;
    localparam logic [127:0] VEC_A    = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] VEC_B    = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] VEC_C    = 128'hdeadbeef_01234567_89abcdef_fedcba98;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         bypass_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    always #5 clk = ~clk;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
`ifdef IMC_BYPASS_EN
        .bypass    (bypass_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    int cyc = 0;
    int pass_cnt = 0;
    int chk_cnt = 0;
    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           hs_cyc [$];
    logic         prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %032h expected %032h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Plain shift-and-add GF(2^8) multiply, reduction polynomial 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Byte i of the state is s[127-8i -: 8]; row r of the matrix is {E,B,D,9} rotated right by r.
    function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
        logic [7:0]   a [4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        r = s;
        if (byp) return s;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k - i + 4) % 4], a[k]);
                r[127 - 32*c - 8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, between active edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    check("state_out", state_out, exp_q[0]);
                    if (!prev_valid) check("latency", 128'(cyc - acc_q[0]), 128'(5));
                    check("in_ready_done", 128'(in_ready), 128'(out_ready));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        hs_cyc.push_back(cyc);
                    end
                end
            end else begin
                check("in_ready", 128'(in_ready), 128'(exp_q.size() == 0));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(state_in, bypass_in));
                acc_q.push_back(cyc);
            end
            prev_valid = out_valid;
        end
    end

    // Returns just after the accepting rising edge.
    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
    endtask

    task automatic send(input logic [127:0] s, input logic byp);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        state_in  = s;
        bypass_in = byp;
        wait_accept();
        #1 in_valid = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check("valid_timeout", 128'(out_valid), 128'(1));
    endtask

    initial begin
        int n;
        int hs_before;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0; bypass_in = 1'b0;

        check("model_kat1", model(KAT1_IN, 1'b0), KAT1_OUT);
        check("model_kat2", model(KAT2_IN, 1'b0), KAT2_OUT);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_state_out", state_out, 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));

        out_ready = 1'b1;
        send(KAT1_IN, 1'b0);
        wait_valid(n);
        check("kat1_latency", 128'(n), 128'(5));
        check("kat1_out", state_out, KAT1_OUT);

        @(posedge clk); #1 out_ready = 1'b0;
        send(KAT2_IN, 1'b0);
        wait_valid(n);
        check("kat2_out", state_out, KAT2_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_state_out", state_out, KAT2_OUT);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        hs_before = hs_cyc.size();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_release_valid", 128'(out_valid), 128'(0));
        repeat (3) @(posedge clk);
        #2 check("bp_one_handshake", 128'(hs_cyc.size() - hs_before), 128'(1));

        // Back-to-back: in_valid stays high, second state waits through the first CALC.
        @(posedge clk); #1;
        in_valid = 1'b1; state_in = VEC_A; bypass_in = 1'b0;
        wait_accept();
        #1 state_in = VEC_B;
        wait_accept();
        #1 in_valid = 1'b0;
        wait_valid(n);
        check("b2b_latency", 128'(n), 128'(5));
        @(posedge clk); #2;
        check("b2b_spacing", 128'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), 128'(5));

        // Reset asserted on the second CALC edge.
        send(VEC_C, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_state_out", state_out, 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 128'(seen), 128'(0));

        send(KAT2_IN, 1'b0);
        wait_valid(n);
        check("post_rst_out", state_out, KAT2_OUT);

`ifdef IMC_BYPASS_EN
        send(KAT1_IN, 1'b1);
        wait_valid(n);
        check("bypass_latency", 128'(n), 128'(5));
        check("bypass_out", state_out, KAT1_IN);
        send(KAT1_IN, 1'b0);
        wait_valid(n);
        check("nobypass_out", state_out, KAT1_OUT);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1 check("drain", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
